// File: rtl/leg_io_host.sv
// Host-side responder for the LEG core I/O port: input FIFO feeds the core, output FIFO captures it.
// Latency: host push -> core-visible head 1 cycle; core emit -> out_valid 1 cycle; arch_input_value combinational.
// Backpressure: in_ready = !input_full; core has no backpressure, so underflow/overflow are flagged (FAULT if STRICT).

module leg_io_host_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign head_dat = mem[rd_ptr];

    // Callers gate push with !full and pop with !empty; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module leg_io_host #(
    parameter int DEPTH  = 16,
    parameter int STRICT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arch_input_enable,
    output logic [7:0]  arch_input_value,
    input  logic        arch_output_enable,
    input  logic [7:0]  arch_output_value,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    input  logic        start,
    input  logic        clear,
    output logic        cpu_rst,
    output logic [1:0]  state,
    output logic        underflow,
    output logic        overflow,
    output logic [15:0] in_count,
    output logic [15:0] out_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     st;
    logic       run;
    logic [7:0] in_head;
    logic [7:0] out_head;
    logic       in_full;
    logic       in_empty;
    logic       out_full;
    logic       out_empty;
    logic       in_push;
    logic       in_pop;
    logic       out_push;
    logic       out_pop;
    logic       uf_evt;
    logic       of_evt;

    assign run = (st == RUN);

    // Full/empty come from pre-edge occupancy, so a same-cycle pop never frees a slot for a push.
    assign in_push  = in_valid && !in_full;
    assign in_pop   = run && arch_input_enable && !in_empty;
    assign uf_evt   = run && arch_input_enable && in_empty;
    assign out_push = run && arch_output_enable && !out_full;
    assign of_evt   = run && arch_output_enable && out_full;
    assign out_pop  = out_ready && !out_empty;

    leg_io_host_fifo #(.DEPTH(DEPTH), .W(8)) u_in_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (clear),
        .push     (in_push),
        .push_dat (in_data),
        .pop      (in_pop),
        .head_dat (in_head),
        .full     (in_full),
        .empty    (in_empty)
    );

    leg_io_host_fifo #(.DEPTH(DEPTH), .W(8)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (clear),
        .push     (out_push),
        .push_dat (arch_output_value),
        .pop      (out_pop),
        .head_dat (out_head),
        .full     (out_full),
        .empty    (out_empty)
    );

    assign arch_input_value = (run && !in_empty) ? in_head : 8'h00;
    assign in_ready         = !in_full;
    assign out_valid        = !out_empty;
    assign out_data         = out_empty ? 8'h00 : out_head;
    assign cpu_rst          = !run;
    assign state            = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            in_count  <= '0;
            out_count <= '0;
        end else if (clear) begin
            st        <= IDLE;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            in_count  <= '0;
            out_count <= '0;
        end else begin
            case (st)
                IDLE:    if (start) st <= RUN;
                RUN:     if ((STRICT != 0) && (uf_evt || of_evt)) st <= FAULT;
                FAULT:   st <= FAULT;
                default: st <= IDLE;
            endcase
            if (uf_evt) underflow <= 1'b1;
            if (of_evt) overflow  <= 1'b1;
            if (in_pop && in_count != 16'hFFFF)    in_count  <= in_count + 16'd1;
            if (out_push && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
        end
    end
endmodule

// File: doc/leg_io_host.md
# leg_io_host

Host-side responder for the LEG core's architectural I/O port. It is the other end of `arch_input_*` and `arch_output_*`. It supplies input bytes to the core from a host-loaded input FIFO and captures bytes the core emits into an output FIFO drained by the host. It holds the core in reset until started, and detects input underflow and output overflow.

## Interface
- `DEPTH`, 16, entries per FIFO; power of two, 2..256
- `STRICT`, 1, 1 = an underflow or overflow moves to FAULT; 0 = flag only, keep running
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `arch_input_enable`  in  1  core is consuming `arch_input_value` this cycle
- `arch_input_value`  out  8  byte presented to the core
- `arch_output_enable`  in  1  core is emitting `arch_output_value` this cycle
- `arch_output_value`  in  8  byte from the core
- `in_valid` / `in_data[7:0]` / `in_ready`  in/in/out  host push into the input FIFO
- `out_valid` / `out_data[7:0]` / `out_ready`  out/out/in  host pop from the output FIFO
- `start`  in  1  pulse: IDLE -> RUN
- `clear`  in  1  pulse: return to IDLE, flush both FIFOs, zero flags and counters
- `cpu_rst`  out  1  reset to the LEG core; high unless state is RUN
- `state`  out  2  IDLE=0, RUN=1, FAULT=2
- `underflow`, `overflow`  out  1  sticky error flags
- `in_count`, `out_count`  out  16  bytes delivered to / captured from the core; saturate at 0xFFFF

## Operation
- **State machine**
  - IDLE -> RUN on `start`.
  - RUN -> FAULT on a new underflow or overflow, only when STRICT=1.
  - Any state -> IDLE on `clear`. `clear` beats `start` when both are high in the same cycle.
  - `start` in RUN or FAULT is ignored. FAULT is left only by `clear`.
- **Input FIFO (first-word-fall-through)**
  - `arch_input_value` = head entry when state=RUN and the FIFO is non-empty; otherwise 0x00.
  - Pop when `arch_input_enable` is high, state=RUN and the FIFO is non-empty.
  - Host push is accepted on `in_valid & in_ready`, in any state, including IDLE preload.
- **Underflow**: `arch_input_enable` high in RUN with the input FIFO empty.
  - The core reads 0x00.
  - `underflow` is set.
  - `in_count` is not incremented.
- **Output FIFO**
  - Push `arch_output_value` when `arch_output_enable` is high in RUN. Core enables are ignored outside RUN.
  - `out_valid` = non-empty; `out_data` = head entry, 0x00 when empty.
  - Pop on `out_valid & out_ready`, in any state.
- **Overflow**: a core push while the output FIFO is full.
  - The byte is dropped.
  - `overflow` is set.
  - `out_count` is not incremented.
- **Full/empty rule**: full and empty are evaluated on pre-edge occupancy.
  - `in_ready` = !input_full. A host push into a full input FIFO is refused even if the core pops in the same cycle.
  - A core push into a full output FIFO overflows even if the host pops in the same cycle.
- **Simultaneous push and pop** on a non-full, non-empty FIFO: occupancy is unchanged and the order is preserved.
- **Counters**: +1 per successful core-side transfer; they hold at 0xFFFF.
- **FAULT state**
  - `cpu_rst` is high.
  - FIFO contents are retained, so the host may still push input and drain output.
- **`clear`** takes effect at the clock edge:
  - both FIFOs are emptied;
  - `underflow`, `overflow` and both counters are zeroed;
  - state becomes IDLE.
  - A transfer attempted in the `clear` cycle is discarded.

## Timing
- **Reset values** (asynchronous, immediate on `rst`):
  - state=IDLE, `cpu_rst`=1
  - `arch_input_value`=0x00, `in_ready`=1
  - `out_valid`=0, `out_data`=0x00
  - `underflow`=`overflow`=0
  - `in_count`=`out_count`=0
  - both FIFOs empty
- `start` in cycle N: state=RUN and `cpu_rst`=0 from cycle N+1.
- `arch_input_value` is combinational from FIFO head and state: it is valid in the same cycle the core samples it. The pop takes effect at the edge ending that cycle, and the next entry is presented in cycle N+1.
- Host push in cycle N: the entry is visible at the head in N+1 at the earliest. There is no same-cycle bypass.
- Core output in cycle N: `out_valid` rises in N+1 at the earliest.
- Error in cycle N: the flag is high from N+1. With STRICT=1, state=FAULT and `cpu_rst`=1 from N+1. A second core event in N is processed normally.
- `rst` asserted mid-RUN: all state is lost immediately and `cpu_rst` goes high asynchronously.

## Test plan
- **Preload and run**: reset; push 0x11, 0x22, 0x33 in IDLE; `start`; core reads one per cycle -> `arch_input_value` shows 0x11, 0x22, 0x33 on consecutive cycles; `in_count`=3; `in_ready` stays high.
- **Echo path**: in RUN, core emits 0xA5 then 0x5A with `out_ready`=0 -> `out_valid`=1 with `out_data`=0xA5; then `out_ready`=1 -> 0xA5 then 0x5A, `out_count`=2.
- **Underflow, STRICT=1**: input FIFO empty, core reads -> value 0x00; next cycle `underflow`=1, state=2, `cpu_rst`=1; later `start` ignored; `clear` -> state=0, flags 0.
- **Overflow, STRICT=0**, DEPTH=4: core emits 5 bytes 1..5 with `out_ready`=0 -> FIFO holds 1..4, `overflow`=1, state remains RUN, `out_count`=4.
- **Full boundary**, DEPTH=4: fill the input FIFO, then in one cycle host pushes 0x99 and core pops -> 0x99 refused (`in_ready`=0), occupancy 3; next cycle push accepted.
- **Reset and clear corners**: assert `rst` mid-RUN with data in both FIFOs -> all reset values immediately. `clear` and `start` in the same cycle -> IDLE, both FIFOs empty.
